// File: rtl/ledsink_if.sv
// ledsink_if: LED-driver link (dck/dai/lat) plus the captured-word write port
// and frame status. The master modport drives the link (driver/bench side);
// the slave modport is the capture block.
interface ledsink_if #(
    parameter int c_ledboards = 30,
    parameter int c_bpc       = 12
);
    localparam int c_channels = c_ledboards * 32;
    localparam int aw         = $clog2(c_channels);

    logic              i_dck;
    logic              i_dai;
    logic              i_lat;
    logic              o_wen;
    logic [aw-1:0]     o_addr;
    logic [c_bpc-1:0]  o_data;
    logic              o_frame;
    logic [aw:0]       o_words;
    logic              o_err;

    modport master (
        output i_dck, i_dai, i_lat,
        input  o_wen, o_addr, o_data, o_frame, o_words, o_err
    );

    modport slave (
        input  i_dck, i_dai, i_lat,
        output o_wen, o_addr, o_data, o_frame, o_words, o_err
    );
endinterface

// File: rtl/ledsink.sv
// ledsink: receive-side capture of the LED-driver stream. Oversamples the
// asynchronous dck/dai/lat lines, deserializes MSB-first words and writes them
// top-down (first word to the farthest channel), pulsing o_frame on each latch.
// Optional framing check: define LEDSINK_CHECK_EN to enable the sticky o_err
// (latch with a partial word, or dck edge after the frame is full).
module ledsink #(
    parameter int c_ledboards = 30,
    parameter int c_bpc       = 12,
    parameter int c_channels  = c_ledboards * 32
) (
    input logic      i_clk,
    input logic      i_rst_n,
    ledsink_if.slave bus
);
    localparam int aw = $clog2(c_channels);
    localparam int ww = aw + 1;
    localparam int bw = (c_bpc > 1) ? $clog2(c_bpc) : 1;

    localparam logic [aw-1:0] last_addr = aw'(c_channels - 1);
    localparam logic [ww-1:0] max_words = ww'(c_channels);
    localparam logic [bw-1:0] last_bit  = bw'(c_bpc - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FULL
    } state_t;

    logic [1:0] dck_sync, dai_sync, lat_sync;
    logic       dck_prev, lat_prev;
    logic       dck_edge, lat_edge, dai_s;

    state_t           state, state_n;
    logic [bw-1:0]    bit_cnt, bit_cnt_n;
    logic [ww-1:0]    word_cnt, word_cnt_n;
    logic [c_bpc-1:0] shreg, shreg_n;
    logic             wen, wen_n;
    logic [aw-1:0]    addr, addr_n;
    logic [c_bpc-1:0] data, data_n;
    logic             frame, frame_n;
    logic [ww-1:0]    words, words_n;

    // Two-flop synchronizers plus previous-value registers for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dck_sync <= '0;
            dai_sync <= '0;
            lat_sync <= '0;
            dck_prev <= 1'b0;
            lat_prev <= 1'b0;
        end else begin
            dck_sync <= {dck_sync[0], bus.i_dck};
            dai_sync <= {dai_sync[0], bus.i_dai};
            lat_sync <= {lat_sync[0], bus.i_lat};
            dck_prev <= dck_sync[1];
            lat_prev <= lat_sync[1];
        end
    end

    assign dck_edge = dck_sync[1] & ~dck_prev;
    assign lat_edge = lat_sync[1] & ~lat_prev;
    assign dai_s    = dai_sync[1];

    // State, counters and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            word_cnt <= '0;
            shreg    <= '0;
            wen      <= 1'b0;
            addr     <= '0;
            data     <= '0;
            frame    <= 1'b0;
            words    <= '0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            word_cnt <= word_cnt_n;
            shreg    <= shreg_n;
            wen      <= wen_n;
            addr     <= addr_n;
            data     <= data_n;
            frame    <= frame_n;
            words    <= words_n;
        end
    end

    // Next-state: latch edge has priority over a same-cycle dck edge
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        word_cnt_n = word_cnt;
        shreg_n    = shreg;
        wen_n      = 1'b0;
        addr_n     = addr;
        data_n     = data;
        frame_n    = 1'b0;
        words_n    = words;

        if (lat_edge) begin
            frame_n    = 1'b1;
            words_n    = word_cnt;
            bit_cnt_n  = '0;
            word_cnt_n = '0;
            shreg_n    = '0;
            state_n    = IDLE;
        end else if (dck_edge && state != FULL) begin
            shreg_n = (shreg << 1) | c_bpc'(dai_s);
            if (bit_cnt == last_bit) begin
                bit_cnt_n  = '0;
                wen_n      = 1'b1;
                data_n     = (shreg << 1) | c_bpc'(dai_s);
                addr_n     = last_addr - word_cnt[aw-1:0];
                word_cnt_n = word_cnt + 1'b1;
                state_n    = (word_cnt + 1'b1 == max_words) ? FULL : SHIFT;
            end else begin
                bit_cnt_n = bit_cnt + 1'b1;
                state_n   = SHIFT;
            end
        end
    end

    assign bus.o_wen   = wen;
    assign bus.o_addr  = addr;
    assign bus.o_data  = data;
    assign bus.o_frame = frame;
    assign bus.o_words = words;

`ifdef LEDSINK_CHECK_EN
    logic err, err_set;

    // Framing violations: latch mid-word, or shifting past a full frame
    always_comb begin
        err_set = 1'b0;
        if (lat_edge) begin
            err_set = (bit_cnt != '0);
        end else if (dck_edge && state == FULL) begin
            err_set = 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

    assign bus.o_err = err;
`else
    assign bus.o_err = 1'b0;
`endif

endmodule
